dct_idct_link: RTL and testbench
================================

Name: dct_idct_link

Overview:
- Synthesizable inter-stage link between the forward DCT output stream and the IDCT input.
- Replaces the fixed 12-bit truncation and sign-extension hard-wired between the two transforms.
- Provides a parametrised coefficient rescaler and a 2-bank ping-pong block buffer (BLK words per bank) with ready/valid drain toward the IDCT.
- Also generates the IDCT approximation-mode select (rapx) from a cycle-window counter.

Parameters:
- IN_W, 32, input coefficient width (two's complement)
- OUT_W, 32, output coefficient width; OUT_W >= IN_W-SHIFT
- SHIFT, 20, right-shift (precision drop) applied to each coefficient; 1..IN_W-2
- BLK, 64, words per block; power of 2
- CNT_W, 32, cycle counter width
- APX_LO, 500000, first cycle (inclusive) of rapx=1 window
- APX_HI, 1000000, end cycle (exclusive) of rapx=1 window

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  DCT done; one coefficient per cycle while high
- din  in  IN_W  DCT coefficient
- out_ready  in  1  IDCT accepts word this cycle
- out_valid  out  1  dout valid; also drives IDCT start
- dout  out  OUT_W  rescaled coefficient
- out_last  out  1  high with the last word of a block
- rapx  out  1  approximation-mode select to IDCT
- ovf  out  1  sticky: at least one block dropped

Behaviour:
Reset:
- out_valid=0, out_last=0, dout=0, rapx=0, ovf=0.
- Both bank-full flags cleared; write and read pointers 0; write bank 0; cycle counter 0.
- Bank contents are undefined after reset.
- Reset mid-block discards all buffered data; no partial output is emitted.

Rescale (combinational on din, applied before write):
- val = din >>> SHIFT (arithmetic shift), sign-extended to OUT_W.

Write FSM, states W_FILL and W_DROP:
- W_FILL, on an in_valid cycle, if the target bank is free, or is freed this same cycle by the final out_valid&&out_ready: write val at wr_ptr, then wr_ptr++.
- When wr_ptr wraps from BLK-1 to 0: set that bank's full flag and toggle the write bank.
- W_FILL, on an in_valid cycle with wr_ptr==0 and the target bank full: go to W_DROP, set ovf, and count this word as dropped.
- W_DROP: discard in_valid words; after BLK words have been dropped in total, return to W_FILL with wr_ptr=0.
- in_valid low mid-block: hold wr_ptr; filling resumes on the next in_valid cycle.

Read FSM, states R_IDLE, R_PRIME, R_STREAM:
- R_IDLE: when the read bank is full, go to R_PRIME and issue the synchronous read of address 0.
- R_PRIME: go to R_STREAM; dout and out_valid are registered outputs.
- R_STREAM: on out_valid&&out_ready, advance rd_ptr and present the next word the following cycle (show-ahead register with zero bubbles).
- out_ready low: hold dout and out_valid stable.
- out_last=1 when the presented word is at rd_ptr==BLK-1.
- On acceptance of the last word: clear the bank-full flag and toggle the read bank.
  - If the other bank is already full, go to R_PRIME; the single bubble is allowed.
  - Otherwise go to R_IDLE with out_valid=0.
- Latency: BLK-th word written at cycle N; the first word appears on dout at cycle N+2.

Mode counter:
- Increments every cycle and saturates at all-ones.
- rapx is registered: 1 when APX_LO <= count < APX_HI, else 0.
- Simultaneous write and read on different banks are fully independent.

Optional Feature:
- Macro: DCT_IDCT_LINK_ROUND_EN.
- Defined: round-half-up, then saturate.
  - val = (din + 2^(SHIFT-1)) >>> SHIFT, computed in IN_W+1 bits.
  - The result is clamped to the OUT_W signed range.
  - Example: din = 2^(IN_W-1)-1 must not wrap negative.
- Undefined: pure truncation as stated above; no adder present.

Test Plan:
- Reset, then 64 in_valid words din=k<<20 (k=0..63), out_ready=1 -> dout=0..63 in order; first at cycle N+2; out_last only on word 63; ovf=0.
- din=-(3<<20) and din=-1 -> dout=-3 and -1 truncated; with DCT_IDCT_LINK_ROUND_EN, din=(5<<20)+(1<<19) -> 6, din=-1 -> 0.
- Three back-to-back blocks with out_ready=0 -> blocks 1 and 2 buffered; block 3 dropped with ovf=1; releasing out_ready outputs blocks 1 then 2 only.
- out_ready toggling 1,0,1,0 during drain -> each word held while out_ready=0; no duplicates or skips across 64 words.
- Last word of bank 0 accepted in the same cycle as first word of a new block targeting bank 0 -> word written, no drop, ovf=0.
- APX_LO=10, APX_HI=20 -> rapx=1 exactly during counts 10..19; reset at count 15 -> rapx=0 and the counter restarts.

Source files
------------

// File: rtl/dct_idct_link_if.sv
// dct_idct_link_if
// Bundles the stream signals between the forward DCT, the inter-stage link
// and the IDCT.
//   in_valid  : DCT output strobe, one coefficient per cycle while high
//   din       : DCT coefficient (IN_W bits, two's complement)
//   out_ready : IDCT accepts the presented word this cycle
//   out_valid : dout holds a valid word (also used as IDCT start)
//   dout      : rescaled coefficient (OUT_W bits, two's complement)
//   out_last  : high together with the last word of a block
//   rapx      : IDCT approximation-mode select
//   ovf       : sticky flag, at least one block was dropped
// master drives the DCT side and the IDCT ready; slave is the link itself.
interface dct_idct_link_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic [IN_W-1:0]  din;
    logic             out_ready;
    logic             out_valid;
    logic [OUT_W-1:0] dout;
    logic             out_last;
    logic             rapx;
    logic             ovf;

    modport master (
        output in_valid, din, out_ready,
        input  out_valid, dout, out_last, rapx, ovf
    );

    modport slave (
        input  in_valid, din, out_ready,
        output out_valid, dout, out_last, rapx, ovf
    );
endinterface

// File: rtl/dct_idct_link.sv
// dct_idct_link
// Link between the forward DCT output stream and the IDCT input. Each incoming
// coefficient is rescaled (arithmetic right shift by SHIFT) and written into a
// two-bank ping-pong buffer of BLK words per bank. Completed banks are drained
// toward the IDCT through a registered ready/valid port. A free-running,
// saturating cycle counter produces the IDCT approximation-mode select rapx,
// which is high while APX_LO <= count < APX_HI.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : dct_idct_link_if.slave (in_valid, din, out_ready, out_valid,
//           dout, out_last, rapx, ovf)
// Build option:
//   DCT_IDCT_LINK_ROUND_EN : round-half-up before the shift and saturate the
//   result to the OUT_W signed range. Undefined gives plain truncation.
module dct_idct_link #(
    parameter int IN_W   = 32,
    parameter int OUT_W  = 32,
    parameter int SHIFT  = 20,
    parameter int BLK    = 64,
    parameter int CNT_W  = 32,
    parameter int APX_LO = 500000,
    parameter int APX_HI = 1000000
) (
    input logic           clk,
    input logic           reset,
    dct_idct_link_if.slave bus
);
    localparam int            PW        = (BLK > 1) ? $clog2(BLK) : 1;
    localparam logic [PW-1:0] LAST_ADDR = PW'(BLK - 1);

    typedef enum logic       {W_FILL, W_DROP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_PRIME, R_STREAM} rd_state_t;

    wr_state_t        wr_state;
    rd_state_t        rd_state;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_next;
    logic [PW-1:0]    drop_cnt;
    logic             wr_bank;
    logic             rd_bank;
    logic [1:0]       bank_full;
    logic [CNT_W-1:0] cycle_cnt;
    logic [OUT_W-1:0] mem [2*BLK];
    logic [OUT_W-1:0] val;
    logic             rd_last_accept;
    logic             wr_free;
    logic             wr_en;
    logic             wr_done;

`ifdef DCT_IDCT_LINK_ROUND_EN
    // One extra bit keeps din + half from wrapping near the positive limit.
    localparam int WW = (OUT_W > IN_W) ? OUT_W + 1 : IN_W + 1;
    localparam logic signed [IN_W:0] HALF    = (IN_W + 1)'(1) <<< (SHIFT - 1);
    localparam logic signed [WW-1:0] OUT_MAX = (WW'(1) <<< (OUT_W - 1)) - WW'(1);
    localparam logic signed [WW-1:0] OUT_MIN = ~OUT_MAX;

    logic signed [IN_W:0]  din_ext;
    logic signed [IN_W:0]  rounded;
    logic signed [WW-1:0]  wide;

    assign din_ext = $signed({bus.din[IN_W-1], bus.din});
    assign rounded = (din_ext + HALF) >>> SHIFT;
    assign wide    = WW'(rounded);

    always_comb begin
        val = OUT_W'(wide);
        if (wide > OUT_MAX) begin
            val = OUT_W'(OUT_MAX);
        end else if (wide < OUT_MIN) begin
            val = OUT_W'(OUT_MIN);
        end
    end
`else
    logic signed [IN_W-1:0] shifted;

    assign shifted = $signed(bus.din) >>> SHIFT;
    assign val     = OUT_W'(shifted);
`endif

    // A bank being released by the final accepted word may be refilled in
    // the same cycle, so a back-to-back block is not dropped.
    assign rd_last_accept = (rd_state == R_STREAM) && bus.out_valid &&
                            bus.out_ready && (rd_ptr == LAST_ADDR);
    assign wr_free        = !bank_full[wr_bank] ||
                            (rd_last_accept && (rd_bank == wr_bank));
    assign wr_en          = (wr_state == W_FILL) && bus.in_valid && wr_free;
    assign wr_done        = wr_en && (wr_ptr == LAST_ADDR);
    assign rd_ptr_next    = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_ptr}] <= val;
        end
    end

    // Write side. A bank can only be full while the write pointer sits at 0,
    // so a refused word always starts a whole-block drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state <= W_FILL;
            wr_ptr   <= '0;
            wr_bank  <= 1'b0;
            drop_cnt <= '0;
            bus.ovf  <= 1'b0;
        end else begin
            case (wr_state)
                W_FILL: begin
                    if (bus.in_valid) begin
                        if (wr_en) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            if (wr_done) begin
                                wr_bank <= ~wr_bank;
                            end
                        end else begin
                            wr_state <= W_DROP;
                            drop_cnt <= PW'(1);
                            bus.ovf  <= 1'b1;
                        end
                    end
                end
                W_DROP: begin
                    if (bus.in_valid) begin
                        if (drop_cnt == LAST_ADDR) begin
                            wr_state <= W_FILL;
                            drop_cnt <= '0;
                        end else begin
                            drop_cnt <= drop_cnt + 1'b1;
                        end
                    end
                end
                default: wr_state <= W_FILL;
            endcase
        end
    end

    // Bank ownership: the writer marks a bank full, the reader releases it.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_full <= '0;
        end else begin
            if (rd_last_accept) begin
                bank_full[rd_bank] <= 1'b0;
            end
            if (wr_done) begin
                bank_full[wr_bank] <= 1'b1;
            end
        end
    end

    // Read side. dout is a show-ahead register loaded straight from the
    // buffer, so the next word follows an accepted one with no bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state      <= R_IDLE;
            rd_ptr        <= '0;
            rd_bank       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.dout      <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (bank_full[rd_bank]) begin
                        rd_state <= R_PRIME;
                    end
                end
                R_PRIME: begin
                    rd_state      <= R_STREAM;
                    rd_ptr        <= '0;
                    bus.dout      <= mem[{rd_bank, PW'(0)}];
                    bus.out_valid <= 1'b1;
                    bus.out_last  <= (BLK == 1);
                end
                R_STREAM: begin
                    if (bus.out_ready) begin
                        if (rd_ptr == LAST_ADDR) begin
                            rd_bank       <= ~rd_bank;
                            rd_ptr        <= '0;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            rd_state      <= bank_full[~rd_bank] ? R_PRIME : R_IDLE;
                        end else begin
                            rd_ptr       <= rd_ptr_next;
                            bus.dout     <= mem[{rd_bank, rd_ptr_next}];
                            bus.out_last <= (rd_ptr_next == LAST_ADDR);
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // Saturating cycle counter and registered approximation-mode window.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
            bus.rapx  <= 1'b0;
        end else begin
            if (cycle_cnt != '1) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
            bus.rapx <= (cycle_cnt >= CNT_W'(APX_LO)) && (cycle_cnt < CNT_W'(APX_HI));
        end
    end
endmodule

// File: tb/tb_dct_idct_link.sv
// tb_dct_idct_link
// Self-checking bench for dct_idct_link. A block-level model (blocks held,
// pending words, drop state, expected output queue) predicts every output and
// is compared against the DUT on each falling clock edge. Literal values pin
// the rescale model and a few directed results.
// Honours DCT_IDCT_LINK_ROUND_EN for the rescale expectations.
module tb_dct_idct_link;
    localparam int IN_W   = 32;
    localparam int OUT_W  = 32;
    localparam int SHIFT  = 20;
    localparam int BLK    = 64;
    localparam int CNT_W  = 32;
    localparam int APX_LO = 10;
    localparam int APX_HI = 20;

`ifdef DCT_IDCT_LINK_ROUND_EN
    localparam longint E0 = -3, E1 = 0, E2 = 6, E3 = 2048;
`else
    localparam longint E0 = -3, E1 = -1, E2 = 5, E3 = 2047;
`endif

    typedef struct {
        logic [OUT_W-1:0] w;
        bit               last;
    } item_t;

    logic clk;
    logic reset;

    dct_idct_link_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    dct_idct_link #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .BLK(BLK),
        .CNT_W(CNT_W), .APX_LO(APX_LO), .APX_HI(APX_HI)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int               nchecks = 0;
    int               nerr    = 0;
    item_t            exp_q[$];
    logic [OUT_W-1:0] pend[$];
    logic [OUT_W-1:0] got[$];
    bit               dropping = 0;
    int               drop_n   = 0;
    int               held     = 0;
    bit               ovf_e    = 0;
    bit               rapx_e   = 0;
    longint           cnt      = 0;
    bit               started  = 0;
    bit               just_reset = 0;
    bit               armed    = 0;
    bit               prev_hold = 0;
    int               ecount   = 0;
    int               expect_at = 0;
    int               idle_run = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

    // Rescale rule written with plain 64-bit arithmetic.
    function automatic logic [OUT_W-1:0] model_rescale(input logic [IN_W-1:0] d);
        longint v;
        longint maxv;
        v = longint'($signed(d));
`ifdef DCT_IDCT_LINK_ROUND_EN
        v = v + (longint'(1) <<< (SHIFT - 1));
`endif
        v = v >>> SHIFT;
`ifdef DCT_IDCT_LINK_ROUND_EN
        maxv = (longint'(1) <<< (OUT_W - 1)) - 1;
        if (v > maxv) v = maxv;
        if (v < -maxv - 1) v = -maxv - 1;
`else
        maxv = 0;
`endif
        return v[OUT_W-1:0] + OUT_W'(maxv - maxv);
    endfunction

    task automatic check_output(input string name, input longint act, input longint exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input bit v, input logic [IN_W-1:0] d, input bit rdy);
        bus.in_valid  = v;
        bus.din       = d;
        bus.out_ready = rdy;
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        apply_stimulus(1'b0, '0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic drain(input string name, input int maxc, input bit toggle);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < maxc) begin
            apply_stimulus(1'b0, '0, toggle ? (n % 2 == 0) : 1'b1);
            n++;
        end
        check_output({name, "_drained"}, exp_q.size(), 0);
    endtask

    // Compare process: check the state left by the last rising edge, then
    // advance the model by the handshakes the next rising edge will sample.
    always @(negedge clk) begin
        bit acc;
        bit fin;
        bit free;
        if (started) begin
            check_output("ovf", bus.ovf, ovf_e);
            check_output("rapx", bus.rapx, rapx_e);
            if (just_reset) begin
                check_output("reset_dout", bus.dout, 0);
            end
            if (prev_hold) begin
                check_output("hold_valid", bus.out_valid, 1);
            end
            if (armed && ecount < expect_at) begin
                check_output("latency_early", bus.out_valid, 0);
            end else if (armed && ecount == expect_at) begin
                check_output("latency", bus.out_valid, 1);
                armed = 0;
            end
            if (!bus.out_valid) begin
                check_output("last_without_valid", bus.out_last, 0);
            end
            if (exp_q.size() == 0) begin
                check_output("idle_valid", bus.out_valid, 0);
                idle_run = 0;
            end else if (bus.out_valid) begin
                check_output("dout", $signed(bus.dout), $signed(exp_q[0].w));
                check_output("out_last", bus.out_last, exp_q[0].last);
                idle_run = 0;
            end else begin
                idle_run++;
                if (idle_run == 5) check_output("stall_cycles", idle_run, 4);
            end
        end
        if (reset) begin
            exp_q.delete();
            pend.delete();
            dropping   = 0;
            drop_n     = 0;
            held       = 0;
            ovf_e      = 0;
            rapx_e     = 0;
            cnt        = 0;
            armed      = 0;
            prev_hold  = 0;
            idle_run   = 0;
            started    = 1;
            just_reset = 1;
        end else if (started) begin
            just_reset = 0;
            acc  = bus.out_valid && bus.out_ready;
            fin  = acc && (exp_q.size() > 0) && exp_q[0].last;
            free = (held < 2) || fin;
            if (bus.in_valid) begin
                if (dropping) begin
                    drop_n++;
                    if (drop_n == BLK) dropping = 0;
                end else if (pend.size() == 0 && !free) begin
                    dropping = 1;
                    drop_n   = 1;
                    ovf_e    = 1;
                end else begin
                    pend.push_back(model_rescale(bus.din));
                    if (pend.size() == BLK) begin
                        if (exp_q.size() == 0) begin
                            armed     = 1;
                            expect_at = ecount + 3;
                        end
                        for (int i = 0; i < BLK; i++) begin
                            exp_q.push_back('{w: pend[i], last: (i == BLK - 1)});
                        end
                        pend.delete();
                        held++;
                    end
                end
            end
            if (acc && exp_q.size() > 0) begin
                got.push_back(bus.dout);
                void'(exp_q.pop_front());
                if (fin) held--;
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            rapx_e    = (cnt >= APX_LO) && (cnt < APX_HI);
            if (cnt != (longint'(1) <<< CNT_W) - 1) cnt++;
        end
        ecount++;
    end

    initial begin
        logic [IN_W-1:0] d [4];
        int n;

        d[0] = IN_W'(-(3 <<< 20));
        d[1] = '1;
        d[2] = IN_W'((5 <<< 20) + (1 <<< 19));
        d[3] = {1'b0, {(IN_W-1){1'b1}}};
        check_output("model_pin_neg3", $signed(model_rescale(d[0])), E0);
        check_output("model_pin_neg1", $signed(model_rescale(d[1])), E1);
        check_output("model_pin_half", $signed(model_rescale(d[2])), E2);
        check_output("model_pin_max", $signed(model_rescale(d[3])), E3);

        reset = 1'b1;
        repeat (3) apply_stimulus(1'b0, '0, 1'b0);
        check_output("rst_out_valid", bus.out_valid, 0);
        check_output("rst_out_last", bus.out_last, 0);
        check_output("rst_dout", bus.dout, 0);
        check_output("rst_rapx", bus.rapx, 0);
        check_output("rst_ovf", bus.ovf, 0);

        // rapx window, then reset at count 15
        reset = 1'b0;
        repeat (15) apply_stimulus(1'b0, '0, 1'b0);
        check_output("rapx_in_window", bus.rapx, 1);
        pulse_reset();
        check_output("rapx_after_reset", bus.rapx, 0);
        repeat (25) apply_stimulus(1'b0, '0, 1'b0);
        check_output("rapx_after_window", bus.rapx, 0);

        $display("[TB] single block k<<20");
        got.delete();
        for (int k = 0; k < BLK; k++) apply_stimulus(1'b1, IN_W'(k <<< 20), 1'b1);
        drain("t1", 200, 1'b0);
        check_output("t1_count", got.size(), BLK);
        for (int k = 0; k < got.size(); k++) check_output($sformatf("t1_word%0d", k), $signed(got[k]), k);
        check_output("t1_ovf", bus.ovf, 0);

        $display("[TB] rescale corner words");
        got.delete();
        for (int k = 0; k < BLK; k++) apply_stimulus(1'b1, (k < 4) ? d[k] : IN_W'($urandom()), 1'b1);
        drain("t2", 200, 1'b0);
        check_output("t2_count", got.size(), BLK);
        if (got.size() >= 4) begin
            check_output("t2_neg3", $signed(got[0]), E0);
            check_output("t2_neg1", $signed(got[1]), E1);
            check_output("t2_half", $signed(got[2]), E2);
            check_output("t2_max", $signed(got[3]), E3);
        end

        $display("[TB] three blocks with sink stalled");
        got.delete();
        for (int k = 0; k < 3 * BLK; k++) apply_stimulus(1'b1, IN_W'($urandom()), 1'b0);
        check_output("t3_ovf_set", bus.ovf, 1);
        drain("t3", 400, 1'b0);
        check_output("t3_count", got.size(), 2 * BLK);
        pulse_reset();
        check_output("t3_ovf_cleared", bus.ovf, 0);

        $display("[TB] toggling out_ready");
        got.delete();
        for (int k = 0; k < BLK; k++) apply_stimulus(1'b1, IN_W'($urandom()), (k % 2 == 0));
        drain("t4", 400, 1'b1);
        check_output("t4_count", got.size(), BLK);

        $display("[TB] refill bank freed in the same cycle");
        got.delete();
        for (int k = 0; k < 2 * BLK; k++) apply_stimulus(1'b1, IN_W'($urandom()), 1'b0);
        n = 0;
        apply_stimulus(1'b0, '0, 1'b1);
        while (!(bus.out_valid && bus.out_last) && n < 200) begin
            apply_stimulus(1'b0, '0, 1'b1);
            n++;
        end
        check_output("t5_found_last", bus.out_valid && bus.out_last, 1);
        for (int k = 0; k < BLK; k++) apply_stimulus(1'b1, IN_W'($urandom()), 1'b1);
        drain("t5", 400, 1'b0);
        check_output("t5_ovf", bus.ovf, 0);
        check_output("t5_count", got.size(), 3 * BLK);

        $display("[TB] random traffic");
        for (int k = 0; k < 600; k++) begin
            apply_stimulus($urandom_range(0, 3) != 0, IN_W'($urandom()), $urandom_range(0, 1) == 1);
        end
        drain("t6", 600, 1'b0);

        $display("[TB] reset mid-block");
        pulse_reset();
        got.delete();
        for (int k = 0; k < 30; k++) apply_stimulus(1'b1, IN_W'($urandom()), 1'b1);
        pulse_reset();
        repeat (BLK + 10) apply_stimulus(1'b0, '0, 1'b1);
        check_output("t7_no_output", got.size(), 0);
        check_output("t7_valid", bus.out_valid, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end
endmodule
